// File: rtl/rv32i_csr_access_ctrl_pkg.sv
// Shared definitions for the RV32I Zicsr access sequencer.
// Contents: data/address widths, CSR funct3 codes, sequencer states,
// the latched-operation payload struct and the write-enable decode helper.
package rv32i_csr_access_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CSR_AW = 12;
    localparam int unsigned F3_W   = 3;

    localparam logic [F3_W-1:0] CSR_F3_RW  = 3'b001;
    localparam logic [F3_W-1:0] CSR_F3_RS  = 3'b010;
    localparam logic [F3_W-1:0] CSR_F3_RC  = 3'b011;
    localparam logic [F3_W-1:0] CSR_F3_RWI = 3'b101;
    localparam logic [F3_W-1:0] CSR_F3_RSI = 3'b110;
    localparam logic [F3_W-1:0] CSR_F3_RCI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } csr_state_e;

    // Operation captured at accept time; src is already rs1 or zimm.
    typedef struct packed {
        logic [F3_W-1:0]   fun3;
        logic [CSR_AW-1:0] addr;
        logic [DATA_W-1:0] src;
        logic              src_zero;
        logic              rd_zero;
    } csr_op_t;

    // Swap forms always write; set/clear forms write only with a nonzero source.
    function automatic logic csr_write_en(input logic [F3_W-1:0] fun3,
                                          input logic            src_zero);
        return (fun3[1:0] == 2'b01) ? 1'b1 : !src_zero;
    endfunction

endpackage

// File: rtl/rv32i_csr_alu.sv
// New CSR value from (funct3, old value, source operand).
// Ports: fun3_i (funct3), old_i (current CSR value), src_i (rs1 or zimm),
//        new_o (value to write back).
module rv32i_csr_alu
    import rv32i_csr_access_ctrl_pkg::*;
(
    input  logic [F3_W-1:0]   fun3_i,
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] src_i,
    output logic [DATA_W-1:0] new_o
);

    always_comb begin
        new_o = old_i;
        case (fun3_i)
            CSR_F3_RW,  CSR_F3_RWI: new_o = src_i;
            CSR_F3_RS,  CSR_F3_RSI: new_o = old_i | src_i;
            CSR_F3_RC,  CSR_F3_RCI: new_o = old_i & ~src_i;
            default:                new_o = old_i;
        endcase
    end

endmodule

// File: rtl/rv32i_csr_access_ctrl.sv
// Execute-stage sequencer for Zicsr instructions: read-modify-write of one
// CSR per accepted op, pipeline stall while busy, old value to rd, and
// illegal-access reporting.
// Ports: clk/rst (async active-high); op_* decoded CSR op; flush from trap/
//        branch logic; csr_rdata combinational CSR read data; stall_req
//        (combinational); csr_re/raddr, csr_we/waddr/wdata CSR file strobes;
//        rd_we/rd_wdata writeback; illegal and done single-cycle pulses.
module rv32i_csr_access_ctrl
    import rv32i_csr_access_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op_fun3,
    input  logic [CSR_AW-1:0] op_addr,
    input  logic [DATA_W-1:0] op_rs1_data,
    input  logic [DATA_W-1:0] op_zimm,
    input  logic              op_src_zero,
    input  logic              op_rd_zero,
    input  logic              flush,
    input  logic [DATA_W-1:0] csr_rdata,
    output logic              stall_req,
    output logic              csr_re,
    output logic [CSR_AW-1:0] csr_raddr,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [DATA_W-1:0] csr_wdata,
    output logic              rd_we,
    output logic [DATA_W-1:0] rd_wdata,
    output logic              illegal,
    output logic              done
);

    csr_state_e        state_q, state_d;
    csr_op_t           op_q, op_d;
    logic [DATA_W-1:0] old_q, old_d;

    logic              csr_re_q, csr_re_d;
    logic [CSR_AW-1:0] csr_raddr_q, csr_raddr_d;
    logic              csr_we_q, csr_we_d;
    logic [CSR_AW-1:0] csr_waddr_q, csr_waddr_d;
    logic [DATA_W-1:0] csr_wdata_q, csr_wdata_d;
    logic              rd_we_q, rd_we_d;
    logic [DATA_W-1:0] rd_wdata_q, rd_wdata_d;
    logic              illegal_q, illegal_d;
    logic              done_q, done_d;

    logic              write_en;
    logic              access_bad;
    logic [DATA_W-1:0] new_val;

    rv32i_csr_alu u_alu (
        .fun3_i (op_q.fun3),
        .old_i  (csr_rdata),
        .src_i  (op_q.src),
        .new_o  (new_val)
    );

    // Decode of the latched op, evaluated while the CSR is being read.
    assign write_en   = csr_write_en(op_q.fun3, op_q.src_zero);
    assign access_bad = (op_q.fun3[1:0] == 2'b00)
                     || (write_en && (op_q.addr[CSR_AW-1 -: 2] == 2'b11));

    assign stall_req = (state_q != ST_IDLE) || op_valid;

    // Next-state and next-output logic; strobes default low every cycle.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        old_d       = old_q;
        csr_re_d    = 1'b0;
        csr_raddr_d = '0;
        csr_we_d    = 1'b0;
        csr_waddr_d = '0;
        csr_wdata_d = '0;
        rd_we_d     = 1'b0;
        rd_wdata_d  = '0;
        illegal_d   = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid && !flush) begin
                    op_d.fun3     = op_fun3;
                    op_d.addr     = op_addr;
                    op_d.src      = op_fun3[2] ? op_zimm : op_rs1_data;
                    op_d.src_zero = op_src_zero;
                    op_d.rd_zero  = op_rd_zero;
                    csr_re_d      = 1'b1;
                    csr_raddr_d   = op_addr;
                    state_d       = ST_READ;
                end
            end
            ST_READ: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    old_d = csr_rdata;
                    if (access_bad) begin
                        illegal_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                    end else if (write_en) begin
                        csr_we_d    = 1'b1;
                        csr_waddr_d = op_q.addr;
                        csr_wdata_d = new_val;
                        state_d     = ST_WRITE;
                    end else begin
                        done_d     = 1'b1;
                        rd_we_d    = !op_q.rd_zero;
                        rd_wdata_d = csr_rdata;
                        state_d    = ST_DONE;
                    end
                end
            end
            // The write has been issued: flush no longer applies.
            ST_WRITE: begin
                done_d     = 1'b1;
                rd_we_d    = !op_q.rd_zero;
                rd_wdata_d = old_q;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            old_q       <= '0;
            csr_re_q    <= 1'b0;
            csr_raddr_q <= '0;
            csr_we_q    <= 1'b0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
            rd_we_q     <= 1'b0;
            rd_wdata_q  <= '0;
            illegal_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            old_q       <= old_d;
            csr_re_q    <= csr_re_d;
            csr_raddr_q <= csr_raddr_d;
            csr_we_q    <= csr_we_d;
            csr_waddr_q <= csr_waddr_d;
            csr_wdata_q <= csr_wdata_d;
            rd_we_q     <= rd_we_d;
            rd_wdata_q  <= rd_wdata_d;
            illegal_q   <= illegal_d;
            done_q      <= done_d;
        end
    end

    assign csr_re    = csr_re_q;
    assign csr_raddr = csr_raddr_q;
    assign csr_we    = csr_we_q;
    assign csr_waddr = csr_waddr_q;
    assign csr_wdata = csr_wdata_q;
    assign rd_we     = rd_we_q;
    assign rd_wdata  = rd_wdata_q;
    assign illegal   = illegal_q;
    assign done      = done_q;

endmodule
